nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operation request.
- start_ready  out  1  block can accept a request.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- done_valid  out  1  result available.
- done_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- c_out  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-004 IDLE behaviour SHALL be:
- start_ready=1, done_valid=0.
- Acceptance = start_valid & start_ready at a rising edge.
- On acceptance: latch a; latch b XOR {W{sub}}; carry register := sub; nibble index := 0; next state RUN.
REQ-005 Each RUN cycle SHALL process exactly one nibble, LSB nibble first:
- P=a_n^b_n, G=a_n&b_n.
- Carries via 4-bit carry-lookahead equations from the carry register (no ripple chain).
- Write S=P^C into result nibble [4i+3:4i].
- Update carry register with the slice carry-out.
- Increment index.
REQ-006 After the RUN cycle for nibble NIBBLES-1, the FSM SHALL enter DONE.
REQ-007 Latency: acceptance at edge t0 SHALL give done_valid=1 from edge t0+NIBBLES (4 cycles at default).
REQ-008 On entering DONE the block SHALL set:
- c_out = final carry.
- ovf = (carry into MSB) XOR (carry out of MSB).
- zero = (result == 0).
REQ-009 In DONE, result, c_out, ovf and zero SHALL hold stable until done_valid & done_ready; on that edge the FSM returns to IDLE.
REQ-010 start_ready SHALL be 0 in RUN and DONE; start_valid and operand changes in those states SHALL be ignored. There is no same-cycle accept-on-complete.
REQ-011 In IDLE and RUN, result/c_out/ovf/zero SHALL retain their previous DONE values; they are valid only while done_valid=1.
REQ-012 Arithmetic SHALL be modulo 2^W. Operands are sampled only at acceptance.

Reset
REQ-013 rst=1 at a rising edge SHALL force, regardless of state:
- State IDLE; start_ready=1; done_valid=0.
- result=0, c_out=0, ovf=0, zero=0.
- Carry register and index cleared.
REQ-014 Reset during RUN or DONE SHALL abort the operation with no completion pulse; reset takes priority over all handshakes.
REQ-015 With rst held high, start_valid SHALL NOT be accepted.

Verification
REQ-016 The bench SHALL cover at least these directed scenarios:
- ADD 0x1234+0x4321, sub=0 -> result 0x5555, c_out=0, ovf=0, zero=0; done_valid exactly 4 cycles after acceptance.
- ADD 0xFFFF+0x0001 -> result 0x0000, c_out=1, ovf=0, zero=1.
- ADD 0x7FFF+0x0001 -> result 0x8000, c_out=0, ovf=1, zero=0.
- SUB 0x0005-0x0007 -> result 0xFFFE, c_out=0, ovf=0; SUB 0x8000-0x0001 -> result 0x7FFF, c_out=1, ovf=1.
- Backpressure: done_ready=0 for 3 cycles in DONE -> outputs and done_valid stable; start_valid pulsed during RUN -> ignored, no second result.
- rst asserted in the 2nd RUN cycle -> next cycle IDLE, start_ready=1, done_valid=0, result=0; a fresh request then completes correctly.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Serial adder/subtractor: one 4-bit carry-lookahead slice per cycle, LSB nibble first.
// Results are captured into the output registers only when the last slice completes.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   c_out,
    output logic                   ovf,
    output logic                   zero
);

    // state | meaning
    // IDLE  | ready for a request, outputs hold last result
    // RUN   | one nibble slice per cycle, index 0 .. NIBBLES-1
    // DONE  | result valid, waiting for done_ready

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_next;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    sum_q;

    logic [3:0]      an;
    logic [3:0]      bn;
    logic [3:0]      p;
    logic [3:0]      g;
    logic [4:0]      c;
    logic [3:0]      s;
    logic [W-1:0]    sum_next;
    logic            last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last)        state_next = DONE;
            DONE:    if (done_ready)  state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign last        = (idx_q == LAST);

    // Lookahead carries for the current slice, all derived from the carry register.
    always_comb begin
        an = a_q[{idx_q, 2'b00} +: 4];
        bn = b_q[{idx_q, 2'b00} +: 4];
        p  = an ^ bn;
        g  = an & bn;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s = p ^ c[3:0];
        sum_next = sum_q;
        sum_next[{idx_q, 2'b00} +: 4] = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {W{sub}};
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= c[4];
                    idx_q   <= last ? '0 : idx_q + 1'b1;
                    if (last) begin
                        result <= sum_next;
                        c_out  <= c[4];
                        ovf    <= c[3] ^ c[4];
                        zero   <= (sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: vector table plus backpressure,
// ignored-request and reset-abort sequences.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .result      (result),
        .c_out       (c_out),
        .ovf         (ovf),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         zr;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for done_valid with a cycle bound; lat counts edges since acceptance.
    task automatic wait_done(input string name, inout int lat);
        while (!done_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_done_seen"}, {31'd0, done_valid}, 32'd1);
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat;
        chk({name, "_ready"}, {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        a = v.a;
        b = v.b;
        sub = v.sub;
        tick();
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = ~v.sub;
        lat = 0;
        wait_done(name, lat);
        chk({name, "_latency"}, lat, NIB);
        chk({name, "_result"}, {16'd0, result}, {16'd0, v.res});
        chk({name, "_c_out"}, {31'd0, c_out}, {31'd0, v.co});
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, v.ov});
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, v.zr});
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk({name, "_back_idle"}, {30'd0, done_valid, start_ready}, 32'd1);
        chk({name, "_hold_idle"}, {16'd0, result}, {16'd0, v.res});
    endtask

    initial begin
        int lat;
        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        tick();
        tick();
        chk("reset_ready_valid", {30'd0, start_ready, done_valid}, 32'h2);
        chk("reset_outputs", {13'd0, c_out, ovf, zero, result}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure in DONE, plus a request pulsed during RUN that must be ignored.
        start_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        sub = 1'b0;
        tick();
        start_valid = 1'b0;
        tick();
        lat = 1;
        start_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        chk("bp_ready_in_run", {31'd0, start_ready}, 32'd0);
        tick();
        lat++;
        start_valid = 1'b0;
        wait_done("bp", lat);
        chk("bp_latency", lat, NIB);
        for (int k = 0; k < 3; k++) begin
            start_valid = 1'b1;
            tick();
            chk($sformatf("bp_hold%0d", k), {14'd0, done_valid, start_ready, result},
                {14'd0, 1'b1, 1'b0, 16'h5555});
            chk($sformatf("bp_flags%0d", k), {29'd0, c_out, ovf, zero}, 32'd0);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_no_second%0d", k), {30'd0, done_valid, start_ready}, 32'd1);
            tick();
        end

        // Reset in the second RUN cycle aborts the operation.
        start_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        sub = 1'b0;
        tick();
        start_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_run_state", {30'd0, start_ready, done_valid}, 32'h2);
        chk("rst_run_outputs", {13'd0, c_out, ovf, zero, result}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rst_run_no_done%0d", k), {30'd0, start_ready, done_valid}, 32'h2);
        end
        run_op("after_rst", vecs[4]);

        // Reset while DONE is pending.
        start_valid = 1'b1;
        a = 16'h7FFF;
        b = 16'h0001;
        sub = 1'b0;
        tick();
        start_valid = 1'b0;
        lat = 0;
        wait_done("rst_done", lat);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_done_state", {30'd0, start_ready, done_valid}, 32'h2);
        chk("rst_done_outputs", {13'd0, c_out, ovf, zero, result}, 32'd0);

        // Requests while rst is held must not be accepted.
        rst = 1'b1;
        start_valid = 1'b1;
        a = 16'h0001;
        b = 16'h0001;
        for (int k = 0; k < 3; k++) tick();
        start_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_held_no_accept", {30'd0, start_ready, done_valid}, 32'h2);
        for (int k = 0; k < 6; k++) tick();
        chk("rst_held_no_done", {30'd0, start_ready, done_valid}, 32'h2);

        run_op("final", vecs[9]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
